// File: rtl/kbd_pkg.sv
// kbd_pkg: scancode constants, decoder state type and character translation helpers
package kbd_pkg;
  localparam logic [6:0] SC_SHIFT = 7'h0E;
  localparam logic [6:0] SC_CAPS = 7'h0F;
  localparam logic [6:0] SC_CTRL = 7'h11;
  localparam logic [6:0] SC_ALT = 7'h12;
  typedef enum logic [1:0] {IDLE, DECODE, PUSH} dec_state_t;
  function automatic logic [6:0] kbd_shift_map(input logic [6:0] c);
    if (c inside {[7'h31:7'h39]}) return c - 7'h10;
    case (c)
      7'h2D: return 7'h3D;
      7'h5E: return 7'h7E;
      7'h5C: return 7'h7C;
      7'h40: return 7'h60;
      7'h5B: return 7'h7B;
      7'h3B: return 7'h2B;
      7'h3A: return 7'h2A;
      7'h5D: return 7'h7D;
      7'h2C: return 7'h3C;
      7'h2E: return 7'h3E;
      7'h2F: return 7'h3F;
      default: return c;
    endcase
  endfunction
  function automatic logic [7:0] kbd_translate(input logic [6:0] code, input logic [3:0] mods);
    logic [6:0] c;
    logic ctl;
    ctl = code inside {7'h08, 7'h09, 7'h0A, 7'h10, [7'h13:7'h15], [7'h1C:7'h1F]};
    c = code;
    if (!ctl) begin
      if (mods[0]) c = kbd_shift_map(c);
      if (c == 7'h5F) c = mods[0] ? 7'h5F : 7'h5C;
      if (c inside {[7'h61:7'h7A]} && (mods[0] ^ mods[3])) c = c - 7'h20;
    end
    if (mods[1] && c[6]) c = c & 7'h1F;
    return {mods[2], c};
  endfunction
endpackage

// File: rtl/kbd_char_fifo.sv
// kbd_char_fifo: DEPTH x 8 character FIFO; head reads 0 when empty, read and write may both succeed when full
module kbd_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [7:0]                   wdata,
  input  logic                         ren,
  output logic [$clog2(DEPTH+1)-1:0]   len,
  output logic                         full,
  output logic [7:0]                   head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_r, do_w;
  assign full = len == LW'(DEPTH);
  assign do_r = ren && len != '0;
  assign do_w = wen && (!full || do_r);
  assign head = len == '0 ? 8'h00 : mem[rp];
  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      len <= '0;
    end else begin
      if (do_w) wp <= wp + 1'b1;
      if (do_r) rp <= rp + 1'b1;
      len <= len + LW'(do_w) - LW'(do_r);
    end
  // Storage needs no reset; occupancy is governed by len
  always_ff @(posedge clk)
    if (do_w) mem[wp] <= wdata;
endmodule

// File: rtl/kbd_decoder.sv
// kbd_decoder: scancode decoder with modifier tracking and character FIFO; autorepeat enabled by KBD_AUTOREPEAT_EN
module kbd_decoder
  import kbd_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [23:0] REPEAT_DELAY  = 24'd13_500_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2_700_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              kbc_len,
  output logic                              kbc_ren,
  input  logic [7:0]                        kbc_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   char_len,
  input  logic                              char_ren,
  output logic [7:0]                        char_out,
  output logic [3:0]                        mod_state,
  output logic                              overflow,
  input  logic                              ovf_clr
);
  dec_state_t state, state_n;
  logic [7:0] sc, ch, ch_n, rep_char, wdata;
  logic [6:0] code;
  logic [3:0] mods;
  logic rel, emit, is_mod, push_w, rep_w, wen, full;
  assign code = sc[6:0];
  assign rel = sc[7];
  assign is_mod = code inside {SC_SHIFT, SC_CTRL, SC_ALT, SC_CAPS};
  assign ch_n = kbd_translate(code, mods);
  assign mod_state = mods;
  assign push_w = state == PUSH && emit;
  assign wen = push_w | rep_w;
  assign wdata = push_w ? ch : rep_char;
  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // Next state; the controller is read only from IDLE and never during reset
  always_comb begin
    state_n = state == IDLE ? (kbc_len ? DECODE : IDLE) : state == DECODE ? PUSH : IDLE;
    kbc_ren = !rst && state == IDLE && kbc_len;
  end
  // Latch the scancode, then decode it: modifiers update and the character is held for PUSH
  always_ff @(posedge clk)
    if (rst) begin
      sc <= '0;
      ch <= '0;
      emit <= 1'b0;
      mods <= '0;
    end else begin
      if (kbc_ren) sc <= kbc_data;
      if (state == DECODE) begin
        emit <= !rel && !is_mod;
        ch <= ch_n;
        mods[0] <= code == SC_SHIFT ? !rel : mods[0];
        mods[1] <= code == SC_CTRL ? !rel : mods[1];
        mods[2] <= code == SC_ALT ? !rel : mods[2];
        mods[3] <= code == SC_CAPS && !rel ? !mods[3] : mods[3];
      end
    end
  kbd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .wen  (wen),
    .wdata(wdata),
    .ren  (char_ren),
    .len  (char_len),
    .full (full),
    .head (char_out)
  );
  // Sticky overflow; a dropping write beats a simultaneous clear
  always_ff @(posedge clk)
    overflow <= rst ? 1'b0 : (wen && full && !char_ren) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
`ifdef KBD_AUTOREPEAT_EN
  logic armed, pend, rep_due;
  logic [6:0] rep_code;
  logic [23:0] timer;
  assign rep_due = armed && (timer == '0 || pend);
  assign rep_w = rep_due && state != PUSH;
  // Arm on an emitted press, disarm on any other press or release of the armed key; a repeat that lands on PUSH waits a cycle
  always_ff @(posedge clk)
    if (rst) begin
      armed <= 1'b0;
      pend <= 1'b0;
      rep_code <= '0;
      rep_char <= '0;
      timer <= '0;
    end else if (state == DECODE && !rel && !is_mod) begin
      armed <= 1'b1;
      pend <= 1'b0;
      rep_code <= code;
      rep_char <= ch_n;
      timer <= REPEAT_DELAY;
    end else if (state == DECODE && (!rel || code == rep_code)) begin
      armed <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= rep_due && state == PUSH;
      timer <= timer == '0 ? REPEAT_PERIOD - 24'd1 : timer - 24'd1;
    end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_w = 1'b0;
  assign rep_char = 8'h00;
`endif
endmodule

// File: tb/tb_kbd_decoder.sv
// tb_kbd_decoder: scoreboard bench for kbd_decoder; autorepeat checks run when KBD_AUTOREPEAT_EN is defined
module tb_kbd_decoder;
  localparam int DEPTH = 8;
`ifdef KBD_AUTOREPEAT_EN
  localparam logic [23:0] RD = 24'd20;
  localparam logic [23:0] RP = 24'd5;
`else
  localparam logic [23:0] RD = 24'd13_500_000;
  localparam logic [23:0] RP = 24'd2_700_000;
`endif
  logic clk = 1'b0, rst = 1'b1, kbc_len = 1'b0, char_ren = 1'b0, ovf_clr = 1'b0;
  logic [7:0] kbc_data = 8'h00;
  logic kbc_ren, overflow;
  logic [3:0] char_len, mod_state;
  logic [7:0] char_out;
  logic [7:0] exp_q[$];
  logic ovf_m = 1'b0;
  int n_tests = 0, n_fail = 0, ren_cnt = 0, r0;

  kbd_decoder #(.FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .kbc_len(kbc_len), .kbc_ren(kbc_ren), .kbc_data(kbc_data),
    .char_len(char_len), .char_ren(char_ren), .char_out(char_out),
    .mod_state(mod_state), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (kbc_ren) ren_cnt <= ren_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One scancode through the decoder; rd pops the head and oc pulses ovf_clr in the PUSH cycle
  task automatic send(input logic [7:0] code, input logic [7:0] ch, input bit rd = 1'b0, input bit oc = 1'b0);
    int l0, w, el;
    bit em, drop;
    em = !code[7] && !(code[6:0] inside {7'h0E, 7'h0F, 7'h11, 7'h12});
    @(negedge clk);
    l0 = int'(char_len);
    kbc_data = code;
    kbc_len = 1'b1;
    #1;
    w = 0;
    while (!kbc_ren && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check($sformatf("ren_%02h", code), kbc_ren, 1);
    @(negedge clk);
    kbc_len = 1'b0;
    #1;
    check("ren_pulse", kbc_ren, 0);
    @(negedge clk);
    check("len_e1", char_len, l0);
    if (rd) begin
      check("head_rd", char_out, exp_q[0]);
      void'(exp_q.pop_front());
      char_ren = 1'b1;
    end
    ovf_clr = oc;
    @(negedge clk);
    char_ren = 1'b0;
    ovf_clr = 1'b0;
    el = l0 - int'(rd);
    drop = em && el >= DEPTH;
    if (em && !drop) begin
      exp_q.push_back(ch);
      el++;
    end
    ovf_m = drop ? 1'b1 : oc ? 1'b0 : ovf_m;
    check("len_e2", char_len, el);
    check("ovf", overflow, ovf_m);
  endtask

  task automatic tap(input logic [7:0] code, input logic [7:0] ch);
    send(code, ch);
    send(code | 8'h80, 8'h00);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check({tag, "_len"}, char_len, exp_q.size());
      check({tag, "_chr"}, char_out, exp_q.pop_front());
      char_ren = 1'b1;
      @(negedge clk);
      char_ren = 1'b0;
    end
    check({tag, "_empty"}, char_len, 0);
    check({tag, "_head0"}, char_out, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_len", char_len, 0);
    check("rst_out", char_out, 0);
    check("rst_mod", mod_state, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ren", kbc_ren, 0);
    rst = 1'b0;
    r0 = ren_cnt;
    tap(8'h61, 8'h61);
    check("t1_ren_cnt", ren_cnt - r0, 2);
    drain("t1");
    send(8'h0E, 8'h00);
    check("t2_shift", mod_state[0], 1);
    tap(8'h32, 8'h22);
    send(8'h8E, 8'h00);
    check("t2_unshift", mod_state[0], 0);
    tap(8'h32, 8'h32);
    drain("t2");
    tap(8'h0F, 8'h00);
    check("t3_caps", mod_state[3], 1);
    tap(8'h61, 8'h41);
    send(8'h0E, 8'h00);
    tap(8'h61, 8'h61);
    send(8'h8E, 8'h00);
    tap(8'h0F, 8'h00);
    check("t3_caps_off", mod_state, 0);
    drain("t3");
    send(8'h11, 8'h00);
    tap(8'h63, 8'h03);
    send(8'h91, 8'h00);
    send(8'h12, 8'h00);
    tap(8'h31, 8'hB1);
    tap(8'h0A, 8'h8A);
    send(8'h92, 8'h00);
    tap(8'h5F, 8'h5C);
    send(8'h0E, 8'h00);
    tap(8'h5F, 8'h5F);
    tap(8'h2D, 8'h3D);
    tap(8'h5C, 8'h7C);
    send(8'h8E, 8'h00);
    drain("t4");
    for (int i = 0; i <= DEPTH; i++) tap(8'(8'h61 + i), 8'(8'h61 + i));
    check("t5_len", char_len, DEPTH);
    check("t5_ovf", overflow, 1);
    send(8'h71, 8'h71, 1'b1, 1'b0);
    send(8'hF1, 8'h00);
    send(8'h72, 8'h72, 1'b0, 1'b1);
    send(8'hF2, 8'h00);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    ovf_m = 1'b0;
    check("t5_clr", overflow, 0);
    drain("t5");
    @(negedge clk);
    char_ren = 1'b1;
    @(negedge clk);
    char_ren = 1'b0;
    check("t5_empty_rd", char_len, 0);
    send(8'h0E, 8'h00);
    tap(8'h61, 8'h41);
    @(negedge clk);
    kbc_data = 8'h62;
    kbc_len = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_ren", kbc_ren, 0);
    check("mid_rst_len", char_len, 0);
    check("mid_rst_out", char_out, 0);
    check("mid_rst_mod", mod_state, 0);
    check("mid_rst_ovf", overflow, 0);
    kbc_len = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_discard", char_len, 0);
    tap(8'h61, 8'h61);
    drain("post_rst");
`ifdef KBD_AUTOREPEAT_EN
    send(8'h71, 8'h71);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check($sformatf("t6_rep_%0d", i), char_len, 1 + (i >= 20 ? (i - 20) / 5 + 1 : 0));
    end
    repeat (5) exp_q.push_back(8'h71);
    send(8'hF1, 8'h00);
    repeat (30) @(negedge clk);
    check("t6_stop", char_len, 6);
    drain("t6");
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
